// File: rtl/inst_mem_pkg.sv
// ============================================================================
//  Module      : inst_mem_pkg
//  Description : Shared constants and types for the loadable instruction
//                memory: NOP encoding, controller state enum, fetch output
//                source select and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_mem_pkg;

    // Default geometry of the instruction memory.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 6;

    // Instruction word used for cleared memory, squashed and bad fetches.
    localparam logic [31:0] INST_NOP = 32'h0000_0000;

    // Controller state.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Where the registered fetch output takes its word from.
    typedef enum logic [1:0] {
        SRC_NOP = 2'd0,   // constant NOP
        SRC_RAM = 2'd1,   // RAM read register
        SRC_BYP = 2'd2    // same-cycle load data captured for write-first
    } src_t;

endpackage

`default_nettype wire

// File: rtl/inst_mem_array.sv
// ============================================================================
//  Module      : inst_mem_array
//  Description : One-write / one-read synchronous RAM, DEPTH x DATA_W.
//                Read data is registered and holds while re is low.
//                No reset on storage or read register.
//  Ports       : clk            - clock, rising edge
//                we/waddr/wdata - write port
//                re/raddr       - read request / address
//                rdata          - registered read data (read-before-write)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_array
    import inst_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // Callers only assert we/re with addresses below DEPTH.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/inst_mem_fetch.sv
// ============================================================================
//  Module      : inst_mem_fetch
//  Description : Loadable instruction memory with a registered fetch port.
//                Holds the fetched word on stall, squashes to NOP on flush,
//                and bypasses same-cycle load data to the fetch (write-first).
//                Optional self-clear after reset, enabled by defining
//                INST_MEM_CLEAR_EN; without it the block runs immediately
//                after reset and memory is undefined until loaded.
//  Ports       : clk, rst                     - clock, sync active-high reset
//                fetch_en, fetch_addr, flush  - fetch request (0 = stall)
//                inst, inst_valid, fetch_err  - registered fetch result
//                busy                         - clearing / in reset
//                ld_valid, ld_ready,
//                ld_addr, ld_data             - program load port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_fetch
    import inst_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              fetch_err,
    output logic              busy,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam logic [DATA_W-1:0] C_NOP = DATA_W'(INST_NOP);

    logic              w_run;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    // ------------------------------------------------------------------
    // Controller: optional clear sequencer
    // ------------------------------------------------------------------
`ifdef INST_MEM_CLEAR_EN
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        busy          = 1'b1;
        ld_ready      = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_cnt == C_LAST) begin
                    w_state_nxt   = RUN;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                end
            end
            RUN: begin
                busy     = 1'b0;
                ld_ready = 1'b1;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign w_run      = (r_state == RUN);
    assign w_clr_addr = r_clr_cnt;
`else
    // No clear phase: the block is only unavailable while reset is held.
    assign w_run      = ~rst;
    assign busy       = rst;
    assign ld_ready   = ~rst;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    // ------------------------------------------------------------------
    // Load / fetch decode
    // ------------------------------------------------------------------
    logic w_fetch_in_range;
    logic w_ld_in_range;
    logic w_ld_we;
    logic w_fetch;
    logic w_ram_re;
    logic w_bypass;

    assign w_fetch_in_range = (int'(fetch_addr) < DEPTH);
    assign w_ld_in_range    = (int'(ld_addr) < DEPTH);
    // Out-of-range loads are handshaken but never reach the array.
    assign w_ld_we          = ld_valid && ld_ready && w_ld_in_range;
    assign w_fetch          = w_run && fetch_en && !flush;
    assign w_ram_re         = w_fetch && w_fetch_in_range;
    // The array reads old data on a same-address collision, so the load
    // word is captured separately and selected instead.
    assign w_bypass         = w_ram_re && w_ld_we && (ld_addr == fetch_addr);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_ram_we    = w_clr_we || w_ld_we;
    assign w_ram_waddr = w_clr_we ? w_clr_addr : ld_addr;
    assign w_ram_wdata = w_clr_we ? C_NOP      : ld_data;

    inst_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (w_ram_waddr),
        .wdata (w_ram_wdata),
        .re    (w_ram_re),
        .raddr (fetch_addr),
        .rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Fetch output registers. The RAM read register only updates on a
    // real in-range fetch, so it also holds through stalls.
    // ------------------------------------------------------------------
    src_t              r_src;
    logic [DATA_W-1:0] r_byp_data;
    logic              r_valid;
    logic              r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src      <= SRC_NOP;
            r_byp_data <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_run && flush) begin
            r_src   <= SRC_NOP;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_fetch) begin
            r_valid <= 1'b1;
            if (!w_fetch_in_range) begin
                r_src <= SRC_NOP;
                r_err <= 1'b1;
            end else if (w_bypass) begin
                r_src      <= SRC_BYP;
                r_byp_data <= ld_data;
                r_err      <= 1'b0;
            end else begin
                r_src <= SRC_RAM;
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        inst = C_NOP;
        case (r_src)
            SRC_RAM: inst = w_ram_rdata;
            SRC_BYP: inst = r_byp_data;
            default: inst = C_NOP;
        endcase
    end

    assign inst_valid = r_valid;
    assign fetch_err  = r_err;

endmodule

`default_nettype wire

// File: doc/inst_mem_fetch.md
# inst_mem_fetch

Parametrised, loadable instruction memory with a registered fetch port for the forwarding/stall pipelined CPU. It replaces a fixed combinational program table with a synchronous-read RAM. Programs are written through a load port; the memory clears itself after reset. The fetch output holds under pipeline stall and squashes to NOP on flush. It sits between the PC register and the IF/ID pipeline register.

## Interface
- `DATA_W`, 32: instruction width.
- `ADDR_W`, 6: word-address width.
- `DEPTH`, 2**ADDR_W: implemented words; `DEPTH` ≤ 2**ADDR_W.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fetch_en` in 1: fetch request; 0 means pipeline stall.
- `fetch_addr` in ADDR_W: word address (PC).
- `flush` in 1: squash the fetched instruction.
- `inst` out DATA_W: registered instruction.
- `inst_valid` out 1: `inst` belongs to a real fetch.
- `fetch_err` out 1: last fetch address was ≥ `DEPTH`.
- `busy` out 1: clearing in progress; fetches are ignored.
- `ld_valid` in 1: load-port write request.
- `ld_ready` out 1: load write accepted this cycle.
- `ld_addr` in ADDR_W: load word address.
- `ld_data` in DATA_W: load word.

## Operation
- States:
  - CLEAR: a counter walks 0..DEPTH-1 and writes NOP (all zeros) to one word per cycle. On the last word the block goes to RUN.
  - RUN: normal fetch and load operation.
- In CLEAR: `busy`=1, `ld_ready`=0, `fetch_en` ignored, `inst_valid`=0.
- In RUN: `busy`=0, `ld_ready`=1. A write happens when `ld_valid && ld_ready`. A load with `ld_addr` ≥ DEPTH is accepted and dropped.
- Fetch happens when RUN, `fetch_en`=1 and `flush`=0. It reads `mem[fetch_addr]`. Next cycle: `inst` = the word, `inst_valid`=1, `fetch_err`=0.
- Out-of-range fetch (`fetch_addr` ≥ DEPTH): next cycle `inst`=NOP, `inst_valid`=1, `fetch_err`=1.
- Stall (`fetch_en`=0, `flush`=0): `inst`, `inst_valid` and `fetch_err` hold their values.
- Flush: next cycle `inst`=NOP, `inst_valid`=0, `fetch_err`=0. Flush takes priority over `fetch_en` in the same cycle.
- Load and fetch to the same address in the same cycle: the fetch returns `ld_data` (write-first bypass).
- `rst` in any state, including mid-CLEAR: go to CLEAR, counter=0. The clear restarts from word 0.

## Timing
- Reset values: `inst`=0, `inst_valid`=0, `fetch_err`=0, `busy`=1, `ld_ready`=0.
- Fetch latency: exactly 1 cycle from the sampling edge to `inst`.
- CLEAR lasts DEPTH cycles after `rst` deasserts. The first fetch is accepted on cycle DEPTH+1.
- Load write latency: 1 cycle. A fetch in the following cycle sees the new word.
- `ld_ready` is a Moore output of state only. It does not depend on `ld_valid`.

## Configuration
- `INST_MEM_CLEAR_EN` defined: CLEAR state as above.
- `INST_MEM_CLEAR_EN` undefined:
  - No CLEAR state and no counter.
  - `busy`=1 only while `rst`=1; the block is in RUN on the first cycle after reset.
  - Memory contents are undefined until loaded.
  - All other behaviour is unchanged.

## Structure
- Shared package `inst_mem_pkg` holds:
  - `INST_NOP` (32'h00000000);
  - state enum `{CLEAR, RUN}`;
  - default `DATA_W`/`ADDR_W` localparams.
- Sub-module `inst_mem_array`: one-write/one-read synchronous RAM, `DEPTH` x `DATA_W`. It has no reset.
- The top holds the FSM, the clear counter, the bypass compare, and the output/stall/flush registers.

## Test plan
- Reset, then hold `rst`=0: `busy`=1 for 64 cycles. Then fetch 0x3F: `inst`=0x00000000, `inst_valid`=1.
- Load 0x00100c22 at addr 1, then fetch 1: `inst`=0x00100c22 one cycle after the fetch edge.
- Fetch addr 1, then hold `fetch_en`=0 for 3 cycles while loading 0x24001044 at addr 2: `inst` stays 0x00100c22.
- `flush`=1 with `fetch_en`=1 and addr 1: next cycle `inst`=0, `inst_valid`=0.
- Same cycle: load 0x43ffc483 at addr 15 and fetch addr 15: next cycle `inst`=0x43ffc483.
- DEPTH=48, fetch addr 50: `inst`=0, `fetch_err`=1. Separately, assert `rst` at clear cycle 20: `busy` is held for a full 48 more cycles after release.
